// File: rtl/midi_patch_sequencer_if.sv
// MIDI byte-stream bundle: incoming byte strobe plus outgoing byte handshake.
// The master side is the sequencer; the slave side is the MIDI environment.
interface midi_patch_sequencer_if;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       tx_valid;
   logic [7:0] tx_byte;
   logic       tx_ready;

   modport master (
      input  rx_valid,
      input  rx_byte,
      input  tx_ready,
      output tx_valid,
      output tx_byte
   );

   modport slave (
      output rx_valid,
      output rx_byte,
      output tx_ready,
      input  tx_valid,
      input  tx_byte
   );
endinterface

// File: rtl/midi_patch_sequencer.sv
// Patch dump / load sequencer: walks the fixed parameter list and either reads
// every entry out as a SysEx stream, or writes a received SysEx stream back in.
module midi_patch_sequencer #(
   parameter int         V_OSC    = 4,
   parameter logic [7:0] SYSEX_ID = 8'h7D
) (
   input  logic                          clk,
   input  logic                          reset_data_N,
   input  logic                          start_send,
   midi_patch_sequencer_if.master        midi,
   output logic [6:0]                    adr,
   output logic                          write,
   output logic                          read,
   output logic                          osc_sel,
   output logic                          com_sel,
   output logic                          m1_sel,
   output logic                          m2_sel,
   output logic                          sysex_data_patch_send,
   inout  wire  [7:0]                    data,
   output logic                          busy,
   output logic                          done,
   output logic                          rx_err
);

   localparam int N  = 17 + 38 * V_OSC;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] N_C      = CW'(N);
   localparam logic [CW-1:0] N_LAST   = CW'(N - 1);
   localparam logic [2:0]    OSC_LAST = 3'(V_OSC - 1);
   localparam logic [6:0]    M_LAST   = 7'(16 * V_OSC - 1);

   typedef enum logic [3:0] {
      IDLE, TX_F0, TX_ID, S_ADR, S_RD, S_CAP, S_TX, TX_F7,
      RX_ID, RX_DATA, W_SET, W_STB, W_HOLD
   } state_t;

   typedef enum logic [1:0] {B_COM, B_OSC, B_M1, B_M2} bank_t;

   state_t        state;
   bank_t         cur_bank, nxt_bank;
   logic [2:0]    cur_osc, nxt_osc;
   logic [2:0]    cur_pos, nxt_pos;
   logic [6:0]    nxt_adr;
   logic [CW-1:0] cnt;
   logic [3:0]    sel;
   logic [1:0]    sync;
   logic          run;
   logic          drive_en;
   logic [7:0]    drive_val;
   logic          hold_full;
   logic [7:0]    hold_byte;
   logic          in_valid;
   logic [7:0]    in_byte;
   logic          tx_valid_r;
   logic [7:0]    tx_byte_r;
   logic          w_phase;

   // Register offsets inside one oscillator's 16-address block
   function automatic logic [3:0] osc_off(input logic [2:0] p);
      case (p)
         3'd0:    return 4'd2;
         3'd1:    return 4'd3;
         3'd2:    return 4'd4;
         3'd3:    return 4'd7;
         3'd4:    return 4'd10;
         default: return 4'd11;
      endcase
   endfunction

   // One-hot select vector ordered {osc, com, m1, m2}
   function automatic logic [3:0] sel_of(input bank_t b);
      case (b)
         B_COM:   return 4'b0100;
         B_OSC:   return 4'b1000;
         B_M1:    return 4'b0010;
         default: return 4'b0001;
      endcase
   endfunction

   assign {osc_sel, com_sel, m1_sel, m2_sel} = sel;
   assign data          = drive_en ? drive_val : 8'hzz;
   assign midi.tx_valid = tx_valid_r;
   assign midi.tx_byte  = tx_byte_r;
   assign run           = sync[1];
   assign w_phase       = (state == W_SET) || (state == W_STB) || (state == W_HOLD);

   // A byte parked during a write is consumed before the live input
   assign in_valid = hold_full | midi.rx_valid;
   assign in_byte  = hold_full ? hold_byte : midi.rx_byte;

   // Reset release is delayed two clocks so the FSM never starts on a partial edge
   always_ff @(posedge clk or negedge reset_data_N) begin
      if (!reset_data_N) sync <= 2'b00;
      else               sync <= {sync[0], 1'b1};
   end

   // Step the parameter-list cursor to the entry after the current one
   always_comb begin
      nxt_bank = cur_bank;
      nxt_osc  = cur_osc;
      nxt_pos  = cur_pos;
      nxt_adr  = adr;
      case (cur_bank)
         B_COM: begin
            if (adr == 7'd1) begin
               nxt_adr = 7'd16;
            end else if (adr == 7'd31) begin
               nxt_bank = B_OSC;
               nxt_osc  = 3'd0;
               nxt_pos  = 3'd0;
               nxt_adr  = {3'd0, osc_off(3'd0)};
            end else begin
               nxt_adr = adr + 7'd1;
            end
         end
         B_OSC: begin
            if (cur_pos == 3'd5) begin
               if (cur_osc == OSC_LAST) begin
                  nxt_bank = B_M1;
                  nxt_adr  = 7'd0;
               end else begin
                  nxt_osc = cur_osc + 3'd1;
                  nxt_pos = 3'd0;
                  nxt_adr = {cur_osc + 3'd1, osc_off(3'd0)};
               end
            end else begin
               nxt_pos = cur_pos + 3'd1;
               nxt_adr = {cur_osc, osc_off(cur_pos + 3'd1)};
            end
         end
         B_M1: begin
            if (adr == M_LAST) begin
               nxt_bank = B_M2;
               nxt_adr  = 7'd0;
            end else begin
               nxt_adr = adr + 7'd1;
            end
         end
         default: begin
            if (adr != M_LAST) nxt_adr = adr + 7'd1;
         end
      endcase
   end

   // Main sequencer: send and receive FSM with registered bus and stream outputs
   always_ff @(posedge clk or negedge reset_data_N) begin
      if (!reset_data_N) begin
         state                 <= IDLE;
         adr                   <= 7'd0;
         write                 <= 1'b1;
         read                  <= 1'b0;
         sel                   <= 4'b0000;
         sysex_data_patch_send <= 1'b0;
         drive_en              <= 1'b0;
         drive_val             <= 8'h00;
         tx_valid_r            <= 1'b0;
         tx_byte_r             <= 8'h00;
         busy                  <= 1'b0;
         done                  <= 1'b0;
         rx_err                <= 1'b0;
         hold_full             <= 1'b0;
         hold_byte             <= 8'h00;
         cnt                   <= '0;
         cur_bank              <= B_COM;
         cur_osc               <= 3'd0;
         cur_pos               <= 3'd0;
      end else if (run) begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_send) begin
                  state                 <= TX_F0;
                  tx_valid_r            <= 1'b1;
                  tx_byte_r             <= 8'hF0;
                  sysex_data_patch_send <= 1'b1;
                  busy                  <= 1'b1;
                  rx_err                <= 1'b0;
                  cnt                   <= '0;
                  cur_bank              <= B_COM;
                  cur_osc               <= 3'd0;
                  cur_pos               <= 3'd0;
                  adr                   <= 7'd1;
               end else if (midi.rx_valid && midi.rx_byte == 8'hF0) begin
                  state  <= RX_ID;
                  busy   <= 1'b1;
                  rx_err <= 1'b0;
               end
            end
            TX_F0: begin
               if (midi.tx_ready) begin
                  tx_byte_r <= SYSEX_ID;
                  state     <= TX_ID;
               end
            end
            TX_ID: begin
               if (midi.tx_ready) begin
                  tx_valid_r <= 1'b0;
                  sel        <= sel_of(cur_bank);
                  state      <= S_ADR;
               end
            end
            S_ADR: begin
               read  <= 1'b1;
               state <= S_RD;
            end
            S_RD: begin
               read  <= 1'b0;
               state <= S_CAP;
            end
            S_CAP: begin
               tx_byte_r  <= data & 8'h7F;
               tx_valid_r <= 1'b1;
               sel        <= 4'b0000;
               state      <= S_TX;
            end
            S_TX: begin
               if (midi.tx_ready) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == N_LAST) begin
                     tx_byte_r <= 8'hF7;
                     state     <= TX_F7;
                  end else begin
                     tx_valid_r <= 1'b0;
                     cur_bank   <= nxt_bank;
                     cur_osc    <= nxt_osc;
                     cur_pos    <= nxt_pos;
                     adr        <= nxt_adr;
                     sel        <= sel_of(nxt_bank);
                     state      <= S_ADR;
                  end
               end
            end
            TX_F7: begin
               if (midi.tx_ready) begin
                  tx_valid_r            <= 1'b0;
                  tx_byte_r             <= 8'h00;
                  sysex_data_patch_send <= 1'b0;
                  busy                  <= 1'b0;
                  done                  <= 1'b1;
                  state                 <= IDLE;
               end
            end
            RX_ID: begin
               if (midi.rx_valid) begin
                  if (midi.rx_byte == SYSEX_ID) begin
                     state    <= RX_DATA;
                     cnt      <= '0;
                     cur_bank <= B_COM;
                     cur_osc  <= 3'd0;
                     cur_pos  <= 3'd0;
                     adr      <= 7'd1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            RX_DATA: begin
               if (in_valid) begin
                  hold_full <= hold_full & midi.rx_valid;
                  if (hold_full && midi.rx_valid) hold_byte <= midi.rx_byte;
                  if (in_byte < 8'h80 && cnt < N_C) begin
                     drive_en  <= 1'b1;
                     drive_val <= in_byte & 8'h7F;
                     sel       <= sel_of(cur_bank);
                     state     <= W_SET;
                  end else if (in_byte == 8'hF7 && cnt == N_C) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     rx_err    <= 1'b1;
                     busy      <= 1'b0;
                     hold_full <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            W_SET: begin
               write <= 1'b0;
               state <= W_STB;
            end
            W_STB: begin
               write <= 1'b1;
               state <= W_HOLD;
            end
            W_HOLD: begin
               drive_en <= 1'b0;
               sel      <= 4'b0000;
               cnt      <= cnt + 1'b1;
               cur_bank <= nxt_bank;
               cur_osc  <= nxt_osc;
               cur_pos  <= nxt_pos;
               adr      <= nxt_adr;
               state    <= RX_DATA;
            end
            default: state <= IDLE;
         endcase
         if (w_phase && midi.rx_valid) begin
            if (hold_full) begin
               rx_err    <= 1'b1;
               busy      <= 1'b0;
               write     <= 1'b1;
               drive_en  <= 1'b0;
               sel       <= 4'b0000;
               hold_full <= 1'b0;
               state     <= IDLE;
            end else begin
               hold_full <= 1'b1;
               hold_byte <= midi.rx_byte;
            end
         end
      end
   end

endmodule

// File: tb/tb_midi_patch_sequencer.sv
// Randomized self-checking bench for midi_patch_sequencer against a list-based
// model of the patch parameter order.
module tb_midi_patch_sequencer;
   localparam int V_OSC = 4;
   localparam int N     = 17 + 38 * V_OSC;

   logic       clk = 1'b0;
   logic       reset_data_N = 1'b0;
   logic       start_send = 1'b0;
   logic [6:0] adr;
   logic       write, read, osc_sel, com_sel, m1_sel, m2_sel;
   logic       sysex_data_patch_send, busy, done, rx_err;
   logic       probe = 1'b0;
   logic       randomReady = 1'b0;
   wire  [7:0] data;

   midi_patch_sequencer_if midi();

   assign data = sysex_data_patch_send ? ({1'b0, adr} ^ 8'h55) : (probe ? 8'h3C : 8'hzz);

   midi_patch_sequencer #(.V_OSC(V_OSC), .SYSEX_ID(8'h7D)) dut (
      .clk(clk), .reset_data_N(reset_data_N), .start_send(start_send), .midi(midi),
      .adr(adr), .write(write), .read(read), .osc_sel(osc_sel), .com_sel(com_sel),
      .m1_sel(m1_sel), .m2_sel(m2_sel), .sysex_data_patch_send(sysex_data_patch_send),
      .data(data), .busy(busy), .done(done), .rx_err(rx_err)
   );

   always #5 clk = ~clk;

   int vectorCount = 0;
   int missCount   = 0;
   logic [7:0] txq[$];
   logic [6:0] wAdr[$];
   logic [3:0] wSel[$];
   logic [7:0] wData[$];
   int readCount = 0, doneCount = 0, txGlitch = 0, dataGlitch = 0;
   logic prevV = 1'b0, prevR = 1'b0, prevW = 1'b1;
   logic [7:0] prevB = 8'h00, prevD = 8'h00;
   logic [6:0] prevA = 7'd0;

   // Expected address of list entry i, derived from the bank layout
   function automatic int expAdr(input int i);
      int k;
      int offs;
      if (i == 0) return 1;
      if (i < 17) return 15 + i;
      k = i - 17;
      if (k < 6 * V_OSC) begin
         case (k % 6)
            0: offs = 2;
            1: offs = 3;
            2: offs = 4;
            3: offs = 7;
            4: offs = 10;
            default: offs = 11;
         endcase
         return 16 * (k / 6) + offs;
      end
      k = k - 6 * V_OSC;
      if (k < 16 * V_OSC) return k;
      return k - 16 * V_OSC;
   endfunction

   // Expected select vector {osc, com, m1, m2} of list entry i
   function automatic logic [3:0] expSel(input int i);
      if (i < 17) return 4'b0100;
      if (i < 17 + 6 * V_OSC) return 4'b1000;
      if (i < 17 + 22 * V_OSC) return 4'b0010;
      return 4'b0001;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectorCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Bus monitor sampled mid-cycle, when all DUT outputs are settled
   always @(negedge clk) begin
      if (midi.tx_valid && midi.tx_ready) txq.push_back(midi.tx_byte);
      if (prevV && !prevR && (!midi.tx_valid || midi.tx_byte != prevB)) txGlitch <= txGlitch + 1;
      if (read) readCount <= readCount + 1;
      if (done) doneCount <= doneCount + 1;
      if (!write) begin
         wAdr.push_back(adr);
         wSel.push_back({osc_sel, com_sel, m1_sel, m2_sel});
         wData.push_back(data);
      end
      if ((!write || !prevW) && (data != prevD || adr != prevA)) dataGlitch <= dataGlitch + 1;
      prevV <= midi.tx_valid;
      prevR <= midi.tx_ready;
      prevB <= midi.tx_byte;
      prevW <= write;
      prevD <= data;
      prevA <= adr;
   end

   // Downstream transmitter readiness, optionally random
   initial begin
      midi.tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         midi.tx_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic clearLog();
      @(posedge clk);
      #2;
      txq.delete(); wAdr.delete(); wSel.delete(); wData.delete();
      readCount = 0; doneCount = 0; txGlitch = 0; dataGlitch = 0;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      @(posedge clk);
      #1;
      midi.rx_valid = 1'b1;
      midi.rx_byte  = b;
      @(posedge clk);
      #1;
      midi.rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic pulseStart();
      @(posedge clk);
      #1 start_send = 1'b1;
      @(posedge clk);
      #1 start_send = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n;
      int startDone;
      n = 0;
      startDone = doneCount;
      while (doneCount == startDone && n < budget) begin
         @(posedge clk);
         n++;
      end
      checkOutput({tag, "_in_time"}, 32'(n < budget), 32'd1);
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic runSend(input string tag);
      int sz;
      logic [7:0] e;
      clearLog();
      pulseStart();
      waitDone(tag, 10000);
      sz = txq.size();
      checkOutput({tag, "_len"}, 32'(sz), 32'(N + 3));
      for (int i = 0; i < sz && i < N + 3; i++) begin
         if (i == 0) e = 8'hF0;
         else if (i == 1) e = 8'h7D;
         else if (i == N + 2) e = 8'hF7;
         else e = (8'(expAdr(i - 2)) ^ 8'h55) & 8'h7F;
         checkOutput($sformatf("%s_byte%0d", tag, i), 32'(txq[i]), 32'(e));
      end
      checkOutput({tag, "_reads"}, 32'(readCount), 32'(N));
      checkOutput({tag, "_dones"}, 32'(doneCount), 32'd1);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_stable"}, 32'(txGlitch), 32'd0);
   endtask

   task automatic checkWrites(input string tag, input int first, input int cnt, input logic [7:0] vals[$]);
      checkOutput({tag, "_writes"}, 32'(wAdr.size()), 32'(cnt));
      for (int i = 0; i < cnt && i < wAdr.size(); i++) begin
         checkOutput($sformatf("%s_adr%0d", tag, i), 32'(wAdr[i]), 32'(expAdr(first + i)));
         checkOutput($sformatf("%s_sel%0d", tag, i), 32'(wSel[i]), 32'(expSel(first + i)));
         checkOutput($sformatf("%s_data%0d", tag, i), 32'(wData[i]), 32'(vals[i]));
      end
   endtask

   initial begin
      logic [7:0] vals[$];
      logic [7:0] b;
      int n;
      midi.rx_valid = 1'b0;
      midi.rx_byte  = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst_adr", 32'(adr), 32'd0);
      checkOutput("rst_strobes", 32'({write, read}), 32'b10);
      checkOutput("rst_sel", 32'({osc_sel, com_sel, m1_sel, m2_sel}), 32'd0);
      checkOutput("rst_flags", 32'({sysex_data_patch_send, busy, done, rx_err, midi.tx_valid}), 32'd0);
      checkOutput("rst_txbyte", 32'(midi.tx_byte), 32'd0);
      probe = 1'b1;
      #1 checkOutput("rst_data_released", 32'(data), 32'h3C);
      probe = 1'b0;
      @(posedge clk);
      #1 reset_data_N = 1'b1;
      repeat (4) @(posedge clk);

      // Full dumps, steady and random backpressure
      runSend("send_ready");
      randomReady = 1'b1;
      runSend("send_random");
      randomReady = 1'b0;

      // Full load of the documented byte ramp
      clearLog();
      vals.delete();
      applyStimulus(8'hF0, $urandom_range(2, 5));
      applyStimulus(8'h7D, $urandom_range(2, 5));
      for (int i = 0; i < N; i++) begin
         b = 8'(i) & 8'h7F;
         vals.push_back(b);
         applyStimulus(b, $urandom_range(2, 5));
      end
      applyStimulus(8'hF7, 10);
      checkWrites("rx_full", 0, N, vals);
      checkOutput("rx_full_stable", 32'(dataGlitch), 32'd0);
      checkOutput("rx_full_done", 32'(doneCount), 32'd1);
      checkOutput("rx_full_err", 32'(rx_err), 32'd0);
      checkOutput("rx_full_busy", 32'(busy), 32'd0);

      // Short load: ten random bytes then an early F7
      clearLog();
      vals.delete();
      applyStimulus(8'hF0, 3);
      applyStimulus(8'h7D, 3);
      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom_range(0, 127));
         vals.push_back(b);
         applyStimulus(b, $urandom_range(2, 5));
      end
      applyStimulus(8'hF7, 10);
      checkWrites("rx_short", 0, 10, vals);
      checkOutput("rx_short_err", 32'(rx_err), 32'd1);
      checkOutput("rx_short_busy", 32'(busy), 32'd0);
      checkOutput("rx_short_done", 32'(doneCount), 32'd0);
      pulseStart();
      #2 checkOutput("send_clears_err", 32'(rx_err), 32'd0);
      waitDone("send_after_err", 10000);

      // Foreign manufacturer ID is ignored without error
      clearLog();
      applyStimulus(8'hF0, 3);
      applyStimulus(8'h7E, 3);
      applyStimulus(8'h12, 6);
      checkOutput("rx_badid_writes", 32'(wAdr.size()), 32'd0);
      checkOutput("rx_badid_busy", 32'(busy), 32'd0);
      checkOutput("rx_badid_err", 32'(rx_err), 32'd0);

      // Holding register overflow: three back-to-back data bytes
      clearLog();
      applyStimulus(8'hF0, 3);
      applyStimulus(8'h7D, 3);
      @(posedge clk);
      #1 midi.rx_valid = 1'b1; midi.rx_byte = 8'h11;
      @(posedge clk);
      #1 midi.rx_byte = 8'h22;
      @(posedge clk);
      #1 midi.rx_byte = 8'h33;
      @(posedge clk);
      #1 midi.rx_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      checkOutput("rx_ovf_writes", 32'(wAdr.size()), 32'd1);
      checkOutput("rx_ovf_err", 32'(rx_err), 32'd1);
      checkOutput("rx_ovf_busy", 32'(busy), 32'd0);

      // Reset during the write strobe of entry 5
      clearLog();
      applyStimulus(8'hF0, 3);
      applyStimulus(8'h7D, 3);
      for (int i = 0; i < 5; i++) applyStimulus(8'(i + 40), 3);
      applyStimulus(8'h45, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (write && n < 10);
      checkOutput("rst_mid_found_stb", 32'(n < 10), 32'd1);
      #1 reset_data_N = 1'b0;
      #1;
      checkOutput("rst_mid_write", 32'(write), 32'd1);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_sel", 32'({osc_sel, com_sel, m1_sel, m2_sel}), 32'd0);
      probe = 1'b1;
      #1 checkOutput("rst_mid_data_released", 32'(data), 32'h3C);
      probe = 1'b0;
      @(posedge clk);
      #1 reset_data_N = 1'b1; start_send = 1'b1;
      @(posedge clk);
      #1 start_send = 1'b0;
      #1 checkOutput("rst_sync_first_edge", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(8'(i + 60), 3);
      repeat (4) @(posedge clk);
      #2;
      checkOutput("rst_mid_writes", 32'(wAdr.size()), 32'd6);
      checkOutput("rst_mid_idle", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/midi_patch_sequencer.md
MIDI_PATCH_SEQUENCER -- requirements
Module: midi_patch_sequencer

Interface
REQ-001 Parameter V_OSC, default 4, oscillators per voice; legal range 1..8.
REQ-002 Parameter SYSEX_ID, default 8'h7D, manufacturer ID byte for patch dumps.
REQ-003 clk  in  1  system clock; all state changes on posedge.
REQ-004 reset_data_N  in  1  reset, asynchronous, active-low.
REQ-005 start_send  in  1  one-cycle request to begin a patch dump; ignored unless idle.
REQ-006 rx_valid, rx_byte  in  1, 8  incoming MIDI byte strobe and value.
REQ-007 tx_valid, tx_byte  out  1, 8  outgoing MIDI byte and valid; the byte transfers when tx_valid and tx_ready are both high.
REQ-008 tx_ready  in  1  downstream MIDI transmitter can accept a byte.
REQ-009 adr  out  7  parameter address.
REQ-010 write  out  1  active-low write strobe; idle high.
REQ-011 read  out  1  active-high read strobe; idle low.
REQ-012 osc_sel, com_sel, m1_sel, m2_sel  out  1 each  bank selects; at most one is high.
REQ-013 sysex_data_patch_send  out  1  high during send mode; enables parameter read-back onto data.
REQ-014 data  inout  8  shared parameter bus; this block drives it only in write phases, otherwise z.
REQ-015 busy, done  out  1, 1  busy = FSM not idle; done = one-cycle pulse at completion.
REQ-016 rx_err  out  1  sticky; set on a short or aborted receive; cleared by start_send or by a new F0.

Function
REQ-017 Parameter sequence, identical for send and receive, in this order:
- COM bank: adr 1, then 16..31 (17 entries).
- OSC bank: for o = 0..V_OSC-1, adr 16o + {2,3,4,7,10,11} (6·V_OSC entries).
- M1 bank: adr 0..16·V_OSC-1.
- M2 bank: adr 0..16·V_OSC-1.
- N = 17 + 38·V_OSC entries (169 when V_OSC = 4).
REQ-018 States: IDLE, TX_F0, TX_ID, S_ADR, S_RD, S_CAP, S_TX, TX_F7, RX_ID, RX_DATA, W_SET, W_STB, W_HOLD.
REQ-019 Send path: start_send in IDLE → TX_F0 (byte F0) → TX_ID (byte SYSEX_ID). Each TX_* state holds tx_valid and tx_byte until the handshake.
REQ-020 Per send entry:
- S_ADR: adr and the select are stable.
- S_RD: read = 1 for exactly one cycle.
- S_CAP: the block samples data.
- S_TX: tx_byte = {1'b0, captured[6:0]}.
REQ-021 adr and the select are stable from S_ADR through S_CAP.
REQ-022 After the last entry: TX_F7 (byte F7), then done pulses and the FSM returns to IDLE.
REQ-023 sysex_data_patch_send is high from TX_F0 through TX_F7 inclusive.
REQ-024 Receive path, while idle: rx byte F0 → RX_ID.
- Next rx byte == SYSEX_ID → RX_DATA, entry index = 0.
- Any other ID byte → IDLE; rx_err unchanged.
REQ-025 In RX_DATA, each rx byte < 8'h80 is written to the current entry via W_SET → W_STB → W_HOLD:
- data = {1'b0, byte[6:0]}, driven in all three states.
- write is low only in W_STB.
- adr and the select are stable through all three states.
REQ-026 After the write, the index increments. When the index reaches N, the next rx byte must be F7; done pulses and the FSM goes to IDLE.
REQ-027 Receive errors: an F7 before N entries, any other status byte (≥ 8'h80), or a data byte after N entries sets rx_err and returns the FSM to IDLE. Writes already issued are kept.
REQ-028 rx_valid arriving during W_SET/W_STB/W_HOLD is captured in a 1-byte holding register. A second arrival before the holding register drains sets rx_err and aborts.
REQ-029 rx bytes are ignored while sending; start_send is ignored while receiving.
REQ-030 Simultaneous start_send and rx_valid F0 in IDLE: send wins, and the F0 is dropped.
REQ-031 Address arithmetic uses 7 bits; entry counters are sized for N and never wrap.

Reset
REQ-032 Asynchronous assert of reset_data_N forces within the same instant:
- FSM to IDLE.
- adr = 0, write = 1, read = 0, all selects = 0.
- sysex_data_patch_send = 0, data = z.
- tx_valid = 0, tx_byte = 0, busy = 0, done = 0, rx_err = 0.
- holding register empty.
REQ-033 Reset mid-operation abandons the transfer; no completion write or strobe is issued after release.
REQ-034 Release is synchronized internally; the first state transition occurs no earlier than the second clk edge after the release.

Verification
REQ-035 Full send with tx_ready held high, model returning data = adr ^ 8'h55: the stream is F0, 7D, 169 bytes each equal to (adr^55)&7F in REQ-017 order, then F7; one done pulse; exactly 169 read pulses.
REQ-036 Full send with tx_ready toggling randomly: the stream is identical to REQ-035; tx_byte is stable while tx_valid=1 and tx_ready=0.
REQ-037 Receive of F0, 7D, bytes 00..A8 (each &7F), F7: 169 write strobes, each with the expected adr/select, data stable across the low pulse; done pulses; rx_err = 0.
REQ-038 Receive of F0, 7D, 10 bytes, F7: exactly 10 writes, rx_err = 1, FSM idle; a subsequent start_send clears rx_err.
REQ-039 Receive of F0, 7E: no writes, returns to idle, rx_err = 0.
REQ-040 Reset asserted during W_STB of entry 5: write returns high immediately, data = z, busy = 0; no further writes after release.
